// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: display fetch has absolute priority,
// pixel writer and host reader share leftover slots round-robin.
module vga_fb_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_valid,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_cnt
);

    typedef enum logic [1:0] {
        G_NONE,
        G_DISP,
        G_WR,
        G_RD
    } grant_e;

    typedef struct packed {
        logic disp;
        logic host;
    } tag_t;

    grant_e        grant;
    logic          last_q;
    logic [AW-1:0] addr_q;
    tag_t          tag_q [MEM_LAT];
    tag_t          tag_out;
    logic [15:0]   stall_q;
    logic [DW-1:0] disp_hold_q;
    logic [DW-1:0] rd_hold_q;

    // last_q=1 means the reader won the previous tie, so the writer is next
    always_comb begin
        grant = G_NONE;
        if (!reset) begin
            if (disp_req)
                grant = G_DISP;
            else if (wr_valid && (!rd_valid || last_q))
                grant = G_WR;
            else if (rd_valid)
                grant = G_RD;
        end
    end

    always_comb begin
        mem_addr = reset ? '0 : addr_q;
        mem_we   = 1'b0;
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        unique case (grant)
            G_DISP: mem_addr = disp_addr;
            G_WR: begin
                mem_addr = wr_addr;
                mem_we   = 1'b1;
                wr_ready = 1'b1;
            end
            G_RD: begin
                mem_addr = rd_addr;
                rd_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_wdata = wr_data;

    // Outputs are gated by reset so in-flight reads never surface
    assign tag_out       = tag_q[MEM_LAT-1];
    assign disp_valid    = tag_out.disp & ~reset;
    assign rd_data_valid = tag_out.host & ~reset;
    assign stall_cnt     = reset ? 16'd0 : stall_q;

    always_comb begin
        disp_data = disp_hold_q;
        rd_data   = rd_hold_q;
        if (reset) begin
            disp_data = '0;
            rd_data   = '0;
        end else begin
            if (disp_valid)
                disp_data = mem_rdata;
            if (rd_data_valid)
                rd_data = mem_rdata;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            last_q      <= 1'b1;
            addr_q      <= '0;
            stall_q     <= 16'd0;
            disp_hold_q <= '0;
            rd_hold_q   <= '0;
            for (int i = 0; i < MEM_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            if (grant == G_WR)
                last_q <= 1'b0;
            else if (grant == G_RD)
                last_q <= 1'b1;
            addr_q <= mem_addr;
            tag_q[0].disp <= (grant == G_DISP);
            tag_q[0].host <= (grant == G_RD);
            for (int i = 1; i < MEM_LAT; i++)
                tag_q[i] <= tag_q[i-1];
            if (wr_valid && !wr_ready && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (disp_valid)
                disp_hold_q <= mem_rdata;
            if (rd_data_valid)
                rd_hold_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: three instances (MEM_LAT 1..3) on shared
// stimulus, each with its own write-first RAM, against a slot-level model.
module tb_vga_fb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        disp_req, wr_valid, rd_valid;
    logic [15:0] disp_addr, wr_addr, wr_data, rd_addr;

    logic [15:0] d_data [3];
    logic [15:0] r_data [3];
    logic [15:0] m_addr [3];
    logic [15:0] m_wdata [3];
    logic [15:0] m_rdata [3];
    logic [15:0] s_cnt [3];
    logic        d_valid [3];
    logic        r_valid [3];
    logic        w_ready [3];
    logic        r_ready [3];
    logic        m_we [3];

    int n_pass = 0;
    int n_total = 0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        logic [15:0] ram [65536];
        logic [15:0] pipe [3];

        vga_fb_arbiter #(.AW(16), .DW(16), .MEM_LAT(g + 1)) dut (
            .vga_clk(clk), .reset(reset),
            .disp_req(disp_req), .disp_addr(disp_addr),
            .disp_data(d_data[g]), .disp_valid(d_valid[g]),
            .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
            .wr_ready(w_ready[g]),
            .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(r_ready[g]),
            .rd_data(r_data[g]), .rd_data_valid(r_valid[g]),
            .mem_addr(m_addr[g]), .mem_we(m_we[g]),
            .mem_wdata(m_wdata[g]), .mem_rdata(m_rdata[g]),
            .stall_cnt(s_cnt[g])
        );

        initial for (int a = 0; a < 65536; a++) ram[a] = init_val(16'(a));

        always @(posedge clk) begin
            if (m_we[g]) ram[m_addr[g]] <= m_wdata[g];
            pipe[0] <= m_we[g] ? m_wdata[g] : ram[m_addr[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        assign m_rdata[g] = pipe[g];
    end

    // Reference model: grants by priority/round-robin rule, returns
    // scheduled into a slot ring at cycle+latency.
    logic [15:0] ref_mem [logic [15:0]];
    int          cyc = 0;
    logic        last_m;
    int          stall_m;
    logic [15:0] addr_m;
    logic [15:0] hold_d [3];
    logic [15:0] hold_r [3];
    logic        sv_d [3][8];
    logic        sv_r [3][8];
    logic [15:0] sd [3][8];

    int          exp_grant;
    logic        exp_we, exp_wrr, exp_rdr;
    logic [15:0] exp_addr, exp_stall;
    logic        exp_dv [3];
    logic        exp_rdv [3];
    logic [15:0] exp_dd [3];
    logic [15:0] exp_rd [3];

    function automatic logic [15:0] rm(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic model_eval();
        int s;
        s = cyc % 8;
        for (int i = 0; i < 3; i++) begin
            exp_dv[i] = 1'b0;
            exp_rdv[i] = 1'b0;
            if (reset) begin
                hold_d[i] = '0;
                hold_r[i] = '0;
            end else begin
                exp_dv[i] = sv_d[i][s];
                exp_rdv[i] = sv_r[i][s];
                if (sv_d[i][s]) hold_d[i] = sd[i][s];
                if (sv_r[i][s]) hold_r[i] = sd[i][s];
            end
            exp_dd[i] = hold_d[i];
            exp_rd[i] = hold_r[i];
            sv_d[i][s] = 1'b0;
            sv_r[i][s] = 1'b0;
        end
        exp_grant = 0;
        exp_we = 1'b0;
        exp_wrr = 1'b0;
        exp_rdr = 1'b0;
        if (reset) begin
            exp_addr = '0;
            exp_stall = '0;
            last_m = 1'b1;
            stall_m = 0;
            addr_m = '0;
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 8; k++) begin
                    sv_d[i][k] = 1'b0;
                    sv_r[i][k] = 1'b0;
                end
        end else begin
            if (disp_req) exp_grant = 1;
            else if (wr_valid && rd_valid) exp_grant = last_m ? 2 : 3;
            else if (wr_valid) exp_grant = 2;
            else if (rd_valid) exp_grant = 3;
            exp_stall = 16'(stall_m);
            case (exp_grant)
                1: exp_addr = disp_addr;
                2: exp_addr = wr_addr;
                3: exp_addr = rd_addr;
                default: exp_addr = addr_m;
            endcase
            exp_we = (exp_grant == 2);
            exp_wrr = (exp_grant == 2);
            exp_rdr = (exp_grant == 3);
            if (wr_valid && exp_grant != 2 && stall_m < 65535) stall_m++;
            if (exp_grant == 2) begin
                ref_mem[wr_addr] = wr_data;
                last_m = 1'b0;
            end
            if (exp_grant == 3) last_m = 1'b1;
            if (exp_grant == 1 || exp_grant == 3)
                for (int i = 0; i < 3; i++) begin
                    sv_d[i][(cyc + i + 1) % 8] = (exp_grant == 1);
                    sv_r[i][(cyc + i + 1) % 8] = (exp_grant == 3);
                    sd[i][(cyc + i + 1) % 8] = rm(exp_addr);
                end
            addr_m = exp_addr;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_req = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        disp_req = 1'b0;
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr = 16'h0040;
        wr_data = 16'h1111;
        rd_addr = 16'h0041;
        disp_addr = 16'h0;
        repeat (3) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (m_we[i] !== 1'b0 || w_ready[i] !== 1'b0 || r_ready[i] !== 1'b0)
                    $display("FAIL reset_grant L%0d we=%b wr=%b rr=%b want 000",
                             i + 1, m_we[i], w_ready[i], r_ready[i]);
                else n_pass++;
                n_total++;
                if (s_cnt[i] !== 16'd0 || m_addr[i] !== 16'd0)
                    $display("FAIL reset_regs L%0d stall=%h addr=%h want 0",
                             i + 1, s_cnt[i], m_addr[i]);
                else n_pass++;
                n_total++;
                if (d_valid[i] !== 1'b0 || r_valid[i] !== 1'b0)
                    $display("FAIL reset_valid L%0d dv=%b rv=%b want 0",
                             i + 1, d_valid[i], r_valid[i]);
                else n_pass++;
            end
            nxt();
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (w_ready[i] !== (k == 0) || r_ready[i] !== (k == 1))
                    $display("FAIL reset_first_tie L%0d c%0d wr=%b rr=%b want %b %b",
                             i + 1, k, w_ready[i], r_ready[i], k == 0, k == 1);
                else n_pass++;
            end
            nxt();
        end
        idle();
    endtask

    task automatic test_display_priority();
        do_reset();
        wr_valid = 1'b1;
        wr_addr = 16'h0200;
        wr_data = 16'h7777;
        for (int k = 0; k < 11; k++) begin
            disp_req = (k < 8);
            disp_addr = 16'(k);
            if (k == 8) wr_valid = 1'b0;
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (w_ready[i] !== exp_wrr)
                    $display("FAIL disp_wready L%0d c%0d got %b want %b",
                             i + 1, k, w_ready[i], exp_wrr);
                else n_pass++;
                n_total++;
                if (d_valid[i] !== exp_dv[i] || d_data[i] !== exp_dd[i])
                    $display("FAIL disp_data L%0d c%0d got %b/%h want %b/%h",
                             i + 1, k, d_valid[i], d_data[i], exp_dv[i], exp_dd[i]);
                else n_pass++;
                if (k == 8) begin
                    n_total++;
                    if (s_cnt[i] !== 16'd8)
                        $display("FAIL disp_stall L%0d got %0d want 8", i + 1, s_cnt[i]);
                    else n_pass++;
                end
            end
            nxt();
        end
        idle();
    endtask

    task automatic test_round_robin();
        do_reset();
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr = 16'($urandom_range(0, 31));
        wr_data = 16'($urandom);
        rd_addr = 16'($urandom_range(0, 31));
        for (int k = 0; k < 12; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (w_ready[i] !== (k % 2 == 0) || r_ready[i] !== (k % 2 == 1))
                    $display("FAIL rr_alt L%0d c%0d wr=%b rr=%b", i + 1, k,
                             w_ready[i], r_ready[i]);
                else n_pass++;
                n_total++;
                if (r_valid[i] !== exp_rdv[i] || r_data[i] !== exp_rd[i])
                    $display("FAIL rr_rdata L%0d c%0d got %b/%h want %b/%h",
                             i + 1, k, r_valid[i], r_data[i], exp_rdv[i], exp_rd[i]);
                else n_pass++;
                n_total++;
                if (s_cnt[i] !== exp_stall)
                    $display("FAIL rr_stall L%0d c%0d got %0d want %0d",
                             i + 1, k, s_cnt[i], exp_stall);
                else n_pass++;
            end
            nxt();
            if (exp_wrr) begin
                wr_addr = 16'($urandom_range(0, 31));
                wr_data = 16'($urandom);
            end
            if (exp_rdr) rd_addr = 16'($urandom_range(0, 31));
        end
        idle();
    endtask

    task automatic test_read_after_write();
        do_reset();
        wr_valid = 1'b1;
        wr_addr = 16'h0123;
        wr_data = 16'hBEEF;
        tick();
        n_total++;
        if (w_ready[0] !== 1'b1 || m_we[0] !== 1'b1)
            $display("FAIL raw_write got wr=%b we=%b want 1 1", w_ready[0], m_we[0]);
        else n_pass++;
        nxt();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr = 16'h0123;
        tick();
        nxt();
        rd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (r_valid[i] !== (k == i) || (k >= i && r_data[i] !== 16'hBEEF))
                    $display("FAIL raw_read L%0d c%0d got %b/%h want %b/beef",
                             i + 1, k, r_valid[i], r_data[i], k == i);
                else n_pass++;
            end
            nxt();
        end
    endtask

    task automatic test_latency_sweep();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            disp_req = ($urandom_range(0, 1) == 1);
            disp_addr = 16'($urandom_range(0, 63));
            if (!rd_valid) begin
                rd_valid = ($urandom_range(0, 1) == 1);
                rd_addr = 16'($urandom_range(0, 63));
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (d_valid[i] !== exp_dv[i] || d_data[i] !== exp_dd[i])
                    $display("FAIL lat_disp L%0d c%0d got %b/%h want %b/%h",
                             i + 1, k, d_valid[i], d_data[i], exp_dv[i], exp_dd[i]);
                else n_pass++;
                n_total++;
                if (r_valid[i] !== exp_rdv[i] || r_data[i] !== exp_rd[i])
                    $display("FAIL lat_host L%0d c%0d got %b/%h want %b/%h",
                             i + 1, k, r_valid[i], r_data[i], exp_rdv[i], exp_rd[i]);
                else n_pass++;
                n_total++;
                if ((d_valid[i] & r_valid[i]) !== 1'b0)
                    $display("FAIL lat_both L%0d c%0d got 1 want 0", i + 1, k);
                else n_pass++;
            end
            nxt();
            if (exp_rdr) rd_valid = 1'b0;
        end
        idle();
    endtask

    task automatic test_midflight_reset();
        do_reset();
        rd_valid = 1'b1;
        rd_addr = 16'h0055;
        tick();
        n_total++;
        if (r_ready[1] !== 1'b1)
            $display("FAIL mid_accept got %b want 1", r_ready[1]);
        else n_pass++;
        nxt();
        rd_valid = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (r_valid[i] !== 1'b0 || d_valid[i] !== 1'b0)
                    $display("FAIL mid_reset L%0d c%0d rv=%b dv=%b want 0",
                             i + 1, k, r_valid[i], d_valid[i]);
                else n_pass++;
            end
            nxt();
            reset = 1'b0;
        end
    endtask

    task automatic test_random_mix();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            reset = ($urandom_range(0, 63) == 0);
            disp_req = ($urandom_range(0, 2) == 0);
            disp_addr = 16'($urandom_range(0, 15));
            if (!wr_valid) begin
                wr_valid = ($urandom_range(0, 1) == 1);
                wr_addr = 16'($urandom_range(0, 15));
                wr_data = 16'($urandom);
            end
            if (!rd_valid) begin
                rd_valid = ($urandom_range(0, 1) == 1);
                rd_addr = 16'($urandom_range(0, 15));
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (m_we[i] !== exp_we || w_ready[i] !== exp_wrr ||
                    r_ready[i] !== exp_rdr || m_addr[i] !== exp_addr)
                    $display("FAIL mix_grant L%0d c%0d we/wr/rr/addr %b%b%b/%h want %b%b%b/%h",
                             i + 1, k, m_we[i], w_ready[i], r_ready[i], m_addr[i],
                             exp_we, exp_wrr, exp_rdr, exp_addr);
                else n_pass++;
                n_total++;
                if (exp_we && m_wdata[i] !== wr_data)
                    $display("FAIL mix_wdata L%0d c%0d got %h want %h",
                             i + 1, k, m_wdata[i], wr_data);
                else n_pass++;
                n_total++;
                if (s_cnt[i] !== exp_stall)
                    $display("FAIL mix_stall L%0d c%0d got %0d want %0d",
                             i + 1, k, s_cnt[i], exp_stall);
                else n_pass++;
                n_total++;
                if (d_valid[i] !== exp_dv[i] || d_data[i] !== exp_dd[i] ||
                    r_valid[i] !== exp_rdv[i] || r_data[i] !== exp_rd[i])
                    $display("FAIL mix_ret L%0d c%0d got %b/%h %b/%h want %b/%h %b/%h",
                             i + 1, k, d_valid[i], d_data[i], r_valid[i], r_data[i],
                             exp_dv[i], exp_dd[i], exp_rdv[i], exp_rd[i]);
                else n_pass++;
            end
            nxt();
            if (exp_wrr || reset) wr_valid = 1'b0;
            if (exp_rdr || reset) rd_valid = 1'b0;
            reset = 1'b0;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_display_priority();
        test_round_robin();
        test_read_after_write();
        test_latency_sweep();
        test_midflight_reset();
        test_random_mix();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
